// File: rtl/riscv_test_monitor.sv
// Completion monitor for riscv-tests images: decodes tohost stores into pass/fail/timeout.
// Optional TEST_MON_FINISH_EN adds a simulation-only report and $finish on termination.
module riscv_test_monitor #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   TOHOST_ADDR = 'h1000,
  parameter int                TIMEOUT     = 5000,
  parameter int                CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                st_valid,
  input  logic [XLEN-1:0]     st_addr,
  input  logic [XLEN-1:0]     st_data,
  input  logic [XLEN/8-1:0]   st_strb,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [XLEN-2:0]     test_num,
  output logic [CNT_W-1:0]    cycles
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  // One extra bit so that TIMEOUT==0 (all-ones after -1) can never match a counter value.
  localparam logic [CNT_W:0]  WD_LAST  = (CNT_W+1)'(TIMEOUT - 1);
  localparam logic [XLEN-1:0] PASS_VAL = {{(XLEN-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic              r_done;
  logic              r_pass;
  logic              r_fail;
  logic              r_tout;
  logic [XLEN-2:0]   r_test_num;
  logic [CNT_W-1:0]  r_cycles;

  logic              w_hit;
  logic              w_wdog;

  assign w_hit  = st_valid && (st_addr == TOHOST_ADDR) && (&st_strb);
  assign w_wdog = (TIMEOUT != 0) && ({1'b0, r_cycles} == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_tout     <= 1'b0;
      r_test_num <= '0;
      r_cycles   <= '0;
    end else if (start) begin
      // Re-arm from any state; a same-cycle tohost hit is discarded.
      r_state    <= S_RUN;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_tout     <= 1'b0;
      r_test_num <= '0;
      r_cycles   <= '0;
    end else if (r_state == S_RUN) begin
      if (w_hit && (st_data == PASS_VAL)) begin
        r_state <= S_PASS;
        r_pass  <= 1'b1;
        r_done  <= 1'b1;
      end else if (w_hit && st_data[0]) begin
        r_state    <= S_FAIL;
        r_fail     <= 1'b1;
        r_done     <= 1'b1;
        r_test_num <= st_data[XLEN-1:1];
      end else if (w_wdog) begin
        r_state <= S_TOUT;
        r_tout  <= 1'b1;
        r_done  <= 1'b1;
      end else if (r_cycles != {CNT_W{1'b1}}) begin
        r_cycles <= r_cycles + 1'b1;
      end
    end
  end

  assign done     = r_done;
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign timeout  = r_tout;
  assign test_num = r_test_num;
  assign cycles   = r_cycles;

`ifdef TEST_MON_FINISH_EN
  logic r_done_d;
  logic r_fin_arm;

  // Report once when done rises, then end the simulation two cycles after the result shows.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done_d  <= 1'b0;
      r_fin_arm <= 1'b0;
    end else begin
      r_done_d <= r_done;
      if (r_done && !r_done_d) begin
        $display("test monitor: result=%s test_num=%0d cycles=%0d",
                 r_pass ? "pass" : (r_fail ? "fail" : "timeout"), r_test_num, r_cycles);
        r_fin_arm <= 1'b1;
      end else if (r_fin_arm) begin
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: three instances (default, short watchdog, narrow counter).
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_strb;

  logic        m_done, m_pass, m_fail, m_tout;
  logic [30:0] m_tnum;
  logic [31:0] m_cyc;
  logic        t_done, t_pass, t_fail, t_tout;
  logic [30:0] t_tnum;
  logic [31:0] t_cyc;
  logic        s_done, s_pass, s_fail, s_tout;
  logic [30:0] s_tnum;
  logic [3:0]  s_cyc;

  always #5 clk = ~clk;

  riscv_test_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_strb(st_strb), .done(m_done), .pass(m_pass), .fail(m_fail),
    .timeout(m_tout), .test_num(m_tnum), .cycles(m_cyc));

  riscv_test_monitor #(.TIMEOUT(100)) u_dut_to (
    .clk(clk), .rst(rst), .start(start), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_strb(st_strb), .done(t_done), .pass(t_pass), .fail(t_fail),
    .timeout(t_tout), .test_num(t_tnum), .cycles(t_cyc));

  riscv_test_monitor #(.TIMEOUT(0), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_strb(st_strb), .done(s_done), .pass(s_pass), .fail(s_fail),
    .timeout(s_tout), .test_num(s_tnum), .cycles(s_cyc));

  typedef struct {
    string       tag;
    int          id;
    logic [3:0]  flags;   // {done, pass, fail, timeout}
    logic [30:0] tnum;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input string tag, input int id, input logic [3:0] flags,
                          input logic [30:0] tnum, input logic [31:0] cyc);
    exp_t e;
    e.tag = tag; e.id = id; e.flags = flags; e.tnum = tnum; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [3:0]  f;
    logic [30:0] tn;
    logic [31:0] cy;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin f = {m_done, m_pass, m_fail, m_tout}; tn = m_tnum; cy = m_cyc; end
        1:       begin f = {t_done, t_pass, t_fail, t_tout}; tn = t_tnum; cy = t_cyc; end
        default: begin f = {s_done, s_pass, s_fail, s_tout}; tn = s_tnum; cy = {28'd0, s_cyc}; end
      endcase
      chk({e.tag, ".flags"}, {28'd0, f}, {28'd0, e.flags});
      chk({e.tag, ".test_num"}, {1'b0, tn}, {1'b0, e.tnum});
      chk({e.tag, ".cycles"}, cy, e.cyc);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tick_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_strb = s;
    tick();
    st_valid = 1'b0;
  endtask

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_PASS = 4'b1100;
  localparam logic [3:0] F_FAIL = 4'b1010;
  localparam logic [3:0] F_TOUT = 4'b1001;
  localparam logic [31:0] TH    = 32'h1000;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no end expected end of stimulus");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b0; start = 1'b0; st_valid = 1'b0;
    st_addr = '0; st_data = '0; st_strb = '0;
    exp_push("rst_m", 0, F_NONE, 0, 0);
    exp_push("rst_t", 1, F_NONE, 0, 0);
    exp_push("rst_s", 2, F_NONE, 0, 0);
    tick();
    rst = 1'b1;
    run(2);
    exp_push("idle", 0, F_NONE, 0, 0);
    tick_store(TH, 32'h1, 4'hF);

    // T1: pass at RUN cycle 20, then sticky
    start = 1'b1;
    exp_push("t1_arm", 0, F_NONE, 0, 0);
    tick();
    start = 1'b0;
    run(19);
    exp_push("t1_c20", 0, F_NONE, 0, 20);
    tick();
    exp_push("t1_pass", 0, F_PASS, 0, 20);
    tick_store(TH, 32'h1, 4'hF);
    run(4);
    exp_push("t1_hold", 0, F_PASS, 0, 20);
    tick_store(TH, 32'hB, 4'hF);

    // T2: fail with test number, sticky against a later pass
    start = 1'b1;
    exp_push("t2_arm", 0, F_NONE, 0, 0);
    tick();
    start = 1'b0;
    run(4);
    exp_push("t2_c5", 0, F_NONE, 0, 5);
    tick();
    exp_push("t2_fail", 0, F_FAIL, 5, 5);
    tick_store(TH, 32'hB, 4'hF);
    exp_push("t2_sticky", 0, F_FAIL, 5, 5);
    tick_store(TH, 32'h1, 4'hF);
    run(2);
    exp_push("t2_frozen", 0, F_FAIL, 5, 5);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_push("t2_max", 0, F_FAIL, 31'h7FFF_FFFF, 0);
    tick_store(TH, 32'hFFFF_FFFF, 4'hF);

    // T4: ignored stores keep the monitor running
    start = 1'b1;
    exp_push("t4_arm", 0, F_NONE, 0, 0);
    tick();
    start = 1'b0;
    exp_push("t4_partial", 0, F_NONE, 0, 1);
    tick_store(TH, 32'h1, 4'b0011);
    exp_push("t4_even", 0, F_NONE, 0, 2);
    tick_store(TH, 32'h2, 4'hF);
    exp_push("t4_addr", 0, F_NONE, 0, 3);
    tick_store(32'h1004, 32'h1, 4'hF);
    st_addr = TH; st_data = 32'h1; st_strb = 4'hF; st_valid = 1'b0;
    exp_push("t4_novalid", 0, F_NONE, 0, 4);
    tick();
    exp_push("t4_zero", 0, F_NONE, 0, 5);
    tick_store(TH, 32'h0, 4'hF);
    exp_push("t4_pass", 0, F_PASS, 0, 5);
    tick_store(TH, 32'h1, 4'hF);

    // T3: watchdog at cycles==99, and hit beating the watchdog
    start = 1'b1;
    exp_push("t3_arm", 1, F_NONE, 0, 0);
    tick();
    start = 1'b0;
    run(98);
    exp_push("t3_c99", 1, F_NONE, 0, 99);
    tick();
    exp_push("t3_tout", 1, F_TOUT, 0, 99);
    exp_push("t3_main", 0, F_NONE, 0, 100);
    tick();
    run(3);
    exp_push("t3_sticky", 1, F_TOUT, 0, 99);
    exp_push("t3_main_pass", 0, F_PASS, 0, 103);
    tick_store(TH, 32'h1, 4'hF);
    start = 1'b1;
    tick();
    start = 1'b0;
    run(98);
    exp_push("t3_c99b", 1, F_NONE, 0, 99);
    tick();
    exp_push("t3_race", 1, F_PASS, 0, 99);
    tick_store(TH, 32'h1, 4'hF);

    // T5: re-arm mid-run (start beats a hit), reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    run(49);
    exp_push("t5_c50", 0, F_NONE, 0, 50);
    tick();
    start = 1'b1;
    exp_push("t5_rearm", 0, F_NONE, 0, 0);
    tick_store(TH, 32'h1, 4'hF);
    start = 1'b0;
    run(9);
    exp_push("t5_c10", 0, F_NONE, 0, 10);
    tick();
    rst = 1'b0;
    exp_push("t5_rst_m", 0, F_NONE, 0, 0);
    exp_push("t5_rst_t", 1, F_NONE, 0, 0);
    exp_push("t5_rst_s", 2, F_NONE, 0, 0);
    tick();
    rst = 1'b1;
    run(4);
    exp_push("t5_idle", 0, F_NONE, 0, 0);
    tick_store(TH, 32'h1, 4'hF);
    exp_push("t5_idle2", 0, F_NONE, 0, 0);
    tick();
    start = 1'b1;
    exp_push("t5_restart", 0, F_NONE, 0, 0);
    tick();
    start = 1'b0;
    exp_push("t5_run", 0, F_NONE, 0, 1);
    tick();

    // T6: narrow counter saturates, no watchdog
    start = 1'b1;
    tick();
    start = 1'b0;
    run(14);
    exp_push("t6_c15", 2, F_NONE, 0, 15);
    tick();
    run(24);
    exp_push("t6_sat", 2, F_NONE, 0, 15);
    exp_push("t6_main", 0, F_NONE, 0, 40);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
